// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
// Optional write-through forwarding is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_done_pulse.sv
// Register-stage completion pulse: one registered cycle high on the edge after en rises.
module regfile_done_pulse
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  logic en_q;
  logic en_d;
  logic done_q;
  logic done_d;

  // Next-state for the en history and the rising-edge detector
  always_comb begin
    en_d   = en;
    done_d = en & ~en_q;
  end

  // History and pulse flops, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Define REGFILE_BYPASS_EN to forward write_data to a read port addressing the register being written.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              register_done
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_active;

  assign wr_active = reg_write && (write_reg != ZERO_ADDR);

  // Next-state of the array; en deliberately plays no part in writes
  always_comb begin
    regs_d = regs_q;
    if (wr_active) begin
      regs_d[write_reg] = write_data;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  // Storage update; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; regs_q[0] is never written so address 0 reads 0
  always_comb begin
    read_data1 = regs_q[read_reg1];
    read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_active && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs_q[read_reg1];
    end
    if (wr_active && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs_q[read_reg2];
    end
`endif
  end

  regfile_done_pulse u_done_pulse (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .done (register_done)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file; expectations are queued as stimulus is driven, then drained.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        en;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        register_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  register_file dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .reg_write     (reg_write),
    .read_reg1     (read_reg1),
    .read_reg2     (read_reg2),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .register_done (register_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.port = port;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  // Pop every queued expectation and compare against the selected DUT output
  task automatic drain();
    sb_item_t    it;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.port)
        0:       got = read_data1;
        1:       got = read_data2;
        default: got = {31'd0, register_done};
      endcase
      check_eq(it.tag, got, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_reg_t(input logic [4:0] addr, input logic [31:0] data);
    reg_write  = 1'b1;
    write_reg  = addr;
    write_data = data;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    reg_write  = 1'b0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    rst       = 1'b0;
    read_reg1 = 5'd5;
    read_reg2 = 5'd31;
    push("rst_rd1", 0, 32'd0);
    push("rst_rd2", 1, 32'd0);
    push("rst_done", 2, 32'd0);
    drain();

    // Write/readback with en high, then with en low
    en = 1'b1;
    write_reg_t(5'd1, 32'd100);
    write_reg_t(5'd2, 32'd200);
    en = 1'b0;
    read_reg1 = 5'd1;
    read_reg2 = 5'd2;
    push("wr_en1_r1", 0, 32'd100);
    push("wr_en1_r2", 1, 32'd200);
    drain();
    write_reg_t(5'd1, 32'd300);
    write_reg_t(5'd2, 32'd400);
    push("wr_en0_r1", 0, 32'd300);
    push("wr_en0_r2", 1, 32'd400);
    drain();
    write_reg_t(5'd1, 32'd100);
    write_reg_t(5'd2, 32'd200);
    push("wr_en0b_r1", 0, 32'd100);
    push("wr_en0b_r2", 1, 32'd200);
    drain();

    // Zero register
    write_reg_t(5'd0, 32'd50);
    read_reg1 = 5'd0;
    read_reg2 = 5'd1;
    push("r0_rd1", 0, 32'd0);
    push("r1_kept", 1, 32'd100);
    drain();
    write_reg_t(5'd1, 32'd50);
    read_reg1 = 5'd1;
    push("r1_50", 0, 32'd50);
    drain();

    // Done pulse: single pulse for a held en, new pulse after a re-rise
    tick();
    en = 1'b1;
    push("done_pre", 2, 32'd0);
    drain();
    for (int i = 0; i < 5; i++) begin
      tick();
      push($sformatf("done_hold%0d", i), 2, (i == 0) ? 32'd1 : 32'd0);
      drain();
    end
    en = 1'b0;
    tick();
    push("done_low", 2, 32'd0);
    drain();
    en = 1'b1;
    tick();
    push("done_again", 2, 32'd1);
    drain();
    tick();
    push("done_again_end", 2, 32'd0);
    drain();
    en = 1'b0;

    // Same-cycle read/write on r3, plus a dropped r0 write seen on port 2
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'hDEADBEEF;
    read_reg1  = 5'd3;
    read_reg2  = 5'd1;
`ifdef REGFILE_BYPASS_EN
    push("rw_before", 0, 32'hDEADBEEF);
`else
    push("rw_before", 0, 32'd0);
`endif
    push("rw_other_port", 1, 32'd50);
    drain();
    tick();
    reg_write = 1'b0;
    push("rw_after", 0, 32'hDEADBEEF);
    drain();
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h12345678;
    read_reg2  = 5'd0;
    push("rw_r0_port2", 1, 32'd0);
    drain();
    tick();
    reg_write = 1'b0;
    push("rw_r0_after", 1, 32'd0);
    drain();

    // Reset priority over a write, reset clearing a pending pulse
    write_reg_t(5'd4, 32'd9);
    read_reg1 = 5'd4;
    push("r4_pre", 0, 32'd9);
    drain();
    en         = 1'b1;
    rst        = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd4;
    write_data = 32'd7;
    read_reg2  = 5'd1;
    tick();
    reg_write = 1'b0;
    push("rstpri_r4", 0, 32'd0);
    push("rstpri_r1", 1, 32'd0);
    push("rstpri_done", 2, 32'd0);
    drain();
    rst = 1'b0;
    tick();
    push("rst_rel_done", 2, 32'd1);
    drain();
    tick();
    push("rst_rel_done_end", 2, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
